// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bus_pkg
// Description : Shared types and constants for the instruction-fetch /
//               load-store memory arbiter: FSM state encoding, transaction
//               owner encoding, default byte-enable and a helper that sizes
//               the fetch-starvation counter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Owner of the single outstanding memory transaction
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Fetches always read a full word
    localparam logic [3:0] BE_DEFAULT = 4'b1111;

    // Width needed to hold 0..limit (at least one bit)
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Combinational winner selection between the fetch and the
//               load/store requester.
//               Macro ARB_ROUND_ROBIN_EN selects round-robin mode (ptr_i is
//               the side preferred on a tie); otherwise fixed priority with
//               a fetch-starvation escape (cnt_i == STARVE_LIMIT -> fetch).
// Ports       : if_req_i  - fetch request
//               ls_req_i  - load/store request
//               ptr_i     - preferred owner on a tie (round-robin build only)
//               cnt_i     - consecutive fetch losses (fixed-priority build)
//               winner_o  - selected owner (meaningful when any req is set)
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
    import bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             if_req_i,
    input  logic             ls_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_e           ptr_i,
`else
    input  logic [CNT_W-1:0] cnt_i,
`endif
    output owner_e           winner_o
);

`ifndef ARB_ROUND_ROBIN_EN
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
`endif

    always_comb begin
        winner_o = OWN_IF;
        if (if_req_i && ls_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner_o = ptr_i;
`else
            // Load/store has priority unless fetch has starved long enough
            winner_o = (cnt_i == LIMIT_C) ? OWN_IF : OWN_LS;
`endif
        end else if (ls_req_i) begin
            winner_o = OWN_LS;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Shares one memory port between instruction fetch (IF) and
//               load/store (LS). One transaction outstanding at a time:
//               IDLE (arbitrate, grant) -> REQ (mem_req_o until mem_gnt_i)
//               -> WAIT (until mem_rvalid_i) -> response one cycle later.
//               jump_en_i discards the response of an in-flight fetch.
//               Macro ARB_ROUND_ROBIN_EN: alternate winners on a tie instead
//               of fixed LS priority with fetch-starvation escape.
// Ports       : clk, rst (async, active low)
//               if_*  - fetch request/grant/response
//               ls_*  - load/store request/grant/response
//               mem_* - memory request/grant/response
//               jump_en_i   - flush of in-flight fetch
//               hold_flag_o - pipeline stall request
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [3:0]  ls_be_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    input  logic        jump_en_i,
    output logic        hold_flag_o
);

    localparam int CNT_W = cnt_width(STARVE_LIMIT);

    state_e      state_q;
    owner_e      owner_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        kill_q;       // in-flight fetch response must be dropped
    logic        if_rvalid_q;
    logic        ls_rvalid_q;
    logic [31:0] if_rdata_q;
    logic [31:0] ls_rdata_q;

    owner_e      winner_d;
    logic        arb_d;        // an arbitration happens this cycle

`ifdef ARB_ROUND_ROBIN_EN
    owner_e      ptr_q;        // side preferred on the next tie
`else
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0] cnt_q;   // consecutive fetch losses
`endif

    arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_arb_pick (
        .if_req_i (if_req_i),
        .ls_req_i (ls_req_i),
`ifdef ARB_ROUND_ROBIN_EN
        .ptr_i    (ptr_q),
`else
        .cnt_i    (cnt_q),
`endif
        .winner_o (winner_d)
    );

    // Reset gates the combinational outputs so they read 0 while rst is low
    assign arb_d    = rst && (state_q == IDLE) && (if_req_i || ls_req_i);
    assign if_gnt_o = arb_d && if_req_i && (winner_d == OWN_IF);
    assign ls_gnt_o = arb_d && ls_req_i && (winner_d == OWN_LS);

    // A fetch keeps the pipeline stalled until the FSM is back in IDLE
    assign hold_flag_o = rst && ((if_req_i && !if_gnt_o) ||
                                 ((state_q != IDLE) && (owner_q == OWN_IF)));

    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign if_rvalid_o = if_rvalid_q;
    assign ls_rvalid_o = ls_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rdata_o  = ls_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            be_q        <= 4'b0000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            kill_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= 32'h0;
            ls_rdata_q  <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= OWN_IF;
`else
            cnt_q       <= '0;
`endif
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_d) begin
                        owner_q <= winner_d;
                        kill_q  <= 1'b0;
                        state_q <= REQ;
                        if (winner_d == OWN_IF) begin
                            addr_q  <= if_addr_i;
                            we_q    <= 1'b0;
                            be_q    <= BE_DEFAULT;
                            wdata_q <= 32'h0;
                        end else begin
                            addr_q  <= ls_addr_i;
                            we_q    <= ls_we_i;
                            be_q    <= ls_be_i;
                            wdata_q <= ls_wdata_i;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        ptr_q <= (winner_d == OWN_IF) ? OWN_LS : OWN_IF;
`else
                        if (winner_d == OWN_IF) begin
                            cnt_q <= '0;
                        end else if (if_req_i && (cnt_q != LIMIT_C)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                    end
                end
                REQ: begin
                    if (jump_en_i && (owner_q == OWN_IF)) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (jump_en_i && (owner_q == OWN_IF)) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        state_q <= IDLE;
                        if (owner_q == OWN_LS) begin
                            ls_rvalid_q <= 1'b1;
                            ls_rdata_q  <= mem_rdata_i;
                        end else if (!kill_q && !jump_en_i) begin
                            // A flush landing with the data still drops it
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= mem_rdata_i;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter: directed vector table,
//               hand-written multi-cycle sequences (flush, reset in REQ,
//               starvation / round-robin) and a randomized run against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int LIMIT = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [3:0]  ls_be = '0;
    logic [31:0] ls_addr = '0, ls_wdata = '0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        jump = 1'b0;

    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_req, mem_we, hold;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be),
        .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt),
        .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .jump_en_i(jump), .hold_flag_o(hold)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [3:0]  ls_be;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic        jump;
        logic        mem_gnt;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
        logic        e_if_gnt;
        logic        e_ls_gnt;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [3:0]  e_mem_be;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic        e_hold;
        logic        e_if_rv;
        logic        e_ls_rv;
        logic [31:0] e_if_rdata;
        logic [31:0] e_ls_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_be = '0;
        ls_addr = '0; ls_wdata = '0; jump = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    // Start of a cycle: 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        clear_inputs();
        rst = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
    endtask

    // One tie arbitration followed by an immediate memory round trip
    task automatic arb_once(output logic [1:0] g);
        cyc();
        clear_inputs();
        if_req = 1'b1; if_addr = 32'h1000;
        ls_req = 1'b1; ls_addr = 32'h3000;
        #3;
        g = {if_gnt, ls_gnt};
        cyc(); mem_gnt = 1'b1;
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1;
    endtask

    // ------------------------------------------------------------------
    // Reference model state (transaction level)
    // ------------------------------------------------------------------
    bit          m_busy, m_acc, m_ls, m_kill, m_pref_ls;
    int          m_loss;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_ls_rdata;
    bit          m_if_rv, m_ls_rv;

    logic [1:0] exp_seq [6];

    initial begin
        logic [1:0] g;
        vec_t v;
        bit w_ls, e_if_gnt, e_ls_gnt, e_hold;

        // ---------------- reset state ----------------
        clear_inputs();
        if_req = 1'b1; ls_req = 1'b1;
        #3;
        chk("reset_if_gnt", if_gnt, 0);
        chk("reset_ls_gnt", ls_gnt, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_hold", hold, 0);
        chk("reset_if_rdata", if_rdata, 0);
        chk("reset_ls_rdata", ls_rdata, 0);
        chk("reset_mem_addr", mem_addr, 0);
        do_reset();

        // ---------------- vector table ----------------
        vecs.push_back('{default: 0});
        vecs.push_back('{if_req: 1'b1, if_addr: 32'h100, e_if_gnt: 1'b1, default: 0});
        vecs.push_back('{mem_gnt: 1'b1, e_mem_req: 1'b1, e_mem_be: 4'hF, e_mem_addr: 32'h100,
                         e_hold: 1'b1, default: 0});
        vecs.push_back('{mem_rvalid: 1'b1, mem_rdata: 32'h13, e_hold: 1'b1, default: 0});
        vecs.push_back('{e_if_rv: 1'b1, e_if_rdata: 32'h13, default: 0});
        vecs.push_back('{mem_rvalid: 1'b1, mem_gnt: 1'b1, mem_rdata: 32'hBAD,
                         e_if_rdata: 32'h13, default: 0});
        vecs.push_back('{e_if_rdata: 32'h13, default: 0});
        vecs.push_back('{if_req: 1'b1, if_addr: 32'h200, ls_req: 1'b1, ls_we: 1'b1,
                         ls_be: 4'h3, ls_addr: 32'h2000, ls_wdata: 32'hDEADBEEF,
                         e_ls_gnt: 1'b1, e_hold: 1'b1, e_if_rdata: 32'h13, default: 0});
        vecs.push_back('{if_req: 1'b1, if_addr: 32'h200, mem_rvalid: 1'b1, mem_rdata: 32'h55,
                         e_mem_req: 1'b1, e_mem_we: 1'b1, e_mem_be: 4'h3,
                         e_mem_addr: 32'h2000, e_mem_wdata: 32'hDEADBEEF,
                         e_hold: 1'b1, e_if_rdata: 32'h13, default: 0});
        vecs.push_back('{if_req: 1'b1, if_addr: 32'h200, mem_gnt: 1'b1,
                         e_mem_req: 1'b1, e_mem_we: 1'b1, e_mem_be: 4'h3,
                         e_mem_addr: 32'h2000, e_mem_wdata: 32'hDEADBEEF,
                         e_hold: 1'b1, e_if_rdata: 32'h13, default: 0});
        vecs.push_back('{if_req: 1'b1, if_addr: 32'h200, mem_rvalid: 1'b1,
                         mem_rdata: 32'h600D, e_hold: 1'b1, e_if_rdata: 32'h13, default: 0});
        vecs.push_back('{if_req: 1'b1, if_addr: 32'h200, e_if_gnt: 1'b1, e_ls_rv: 1'b1,
                         e_ls_rdata: 32'h600D, e_if_rdata: 32'h13, default: 0});
        vecs.push_back('{mem_gnt: 1'b1, e_mem_req: 1'b1, e_mem_be: 4'hF, e_mem_addr: 32'h200,
                         e_hold: 1'b1, e_if_rdata: 32'h13, e_ls_rdata: 32'h600D, default: 0});
        vecs.push_back('{mem_rvalid: 1'b1, mem_rdata: 32'h1234, e_hold: 1'b1,
                         e_if_rdata: 32'h13, e_ls_rdata: 32'h600D, default: 0});
        vecs.push_back('{e_if_rv: 1'b1, e_if_rdata: 32'h1234, e_ls_rdata: 32'h600D, default: 0});

        foreach (vecs[i]) begin
            v = vecs[i];
            cyc();
            if_req = v.if_req; if_addr = v.if_addr; ls_req = v.ls_req; ls_we = v.ls_we;
            ls_be = v.ls_be; ls_addr = v.ls_addr; ls_wdata = v.ls_wdata; jump = v.jump;
            mem_gnt = v.mem_gnt; mem_rvalid = v.mem_rvalid; mem_rdata = v.mem_rdata;
            #3;
            chk($sformatf("vec%0d_if_gnt", i), if_gnt, v.e_if_gnt);
            chk($sformatf("vec%0d_ls_gnt", i), ls_gnt, v.e_ls_gnt);
            chk($sformatf("vec%0d_mem_req", i), mem_req, v.e_mem_req);
            chk($sformatf("vec%0d_hold", i), hold, v.e_hold);
            chk($sformatf("vec%0d_if_rvalid", i), if_rvalid, v.e_if_rv);
            chk($sformatf("vec%0d_ls_rvalid", i), ls_rvalid, v.e_ls_rv);
            chk($sformatf("vec%0d_if_rdata", i), if_rdata, v.e_if_rdata);
            chk($sformatf("vec%0d_ls_rdata", i), ls_rdata, v.e_ls_rdata);
            if (v.e_mem_req) begin
                chk($sformatf("vec%0d_mem_we", i), mem_we, v.e_mem_we);
                chk($sformatf("vec%0d_mem_be", i), mem_be, v.e_mem_be);
                chk($sformatf("vec%0d_mem_addr", i), mem_addr, v.e_mem_addr);
                chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, v.e_mem_wdata);
            end
        end

        // ---------------- flush of a fetch in WAIT ----------------
        cyc(); clear_inputs(); if_req = 1'b1; if_addr = 32'h300;
        #3 chk("jmp_if_gnt", if_gnt, 1);
        cyc(); clear_inputs(); mem_gnt = 1'b1;
        cyc(); clear_inputs(); jump = 1'b1;
        #3 chk("jmp_hold_wait", hold, 1);
        cyc(); clear_inputs(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
        cyc(); clear_inputs();
        #3 chk("jmp_if_rvalid", if_rvalid, 0);
        chk("jmp_hold_drop", hold, 0);
        cyc(); clear_inputs(); ls_req = 1'b1; ls_addr = 32'h40;
        #3 chk("jmp_back_idle", ls_gnt, 1);
        cyc(); clear_inputs(); mem_gnt = 1'b1; jump = 1'b1;
        cyc(); clear_inputs(); mem_rvalid = 1'b1; mem_rdata = 32'h77; jump = 1'b1;
        cyc(); clear_inputs();
        #3 chk("jmp_ls_rvalid", ls_rvalid, 1);
        chk("jmp_ls_rdata", ls_rdata, 32'h77);

        // ---------------- memory stall then reset in REQ ----------------
        cyc(); clear_inputs(); if_req = 1'b1; if_addr = 32'h400;
        #3 chk("stall_if_gnt", if_gnt, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(); clear_inputs();
            #3 chk($sformatf("stall%0d_mem_req", k), mem_req, 1);
            chk($sformatf("stall%0d_mem_addr", k), mem_addr, 32'h400);
        end
        cyc(); if_req = 1'b1;
        rst = 1'b0;
        #1 chk("rst_mem_req", mem_req, 0);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_hold", hold, 0);
        chk("rst_mem_addr", mem_addr, 0);
        cyc(); rst = 1'b1; clear_inputs(); mem_rvalid = 1'b1; mem_rdata = 32'h99;
        #3 chk("post_rst_mem_req", mem_req, 0);
        cyc(); clear_inputs();
        #3 chk("post_rst_if_rvalid", if_rvalid, 0);
        chk("post_rst_if_rdata", if_rdata, 0);

        // ---------------- continuous tie arbitration ----------------
        if (RR) begin
            for (int k = 0; k < 6; k++) exp_seq[k] = (k % 2 == 0) ? 2'b10 : 2'b01;
        end else begin
            for (int k = 0; k < 6; k++) exp_seq[k] = (k == LIMIT) ? 2'b10 : 2'b01;
        end
        for (int k = 0; k < 6; k++) begin
            arb_once(g);
            chk($sformatf("arb%0d_winner", k), g, exp_seq[k]);
        end

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        m_busy = 0; m_acc = 0; m_ls = 0; m_kill = 0; m_pref_ls = 0; m_loss = 0;
        m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_ls_rdata = 0;
        m_if_rv = 0; m_ls_rv = 0;
        for (int c = 0; c < 400; c++) begin
            cyc();
            if_req     = ($urandom_range(0, 9) < 6);
            if_addr    = $urandom;
            ls_req     = ($urandom_range(0, 9) < 5);
            ls_we      = $urandom_range(0, 1);
            ls_be      = 4'($urandom_range(0, 15));
            ls_addr    = $urandom;
            ls_wdata   = $urandom;
            mem_gnt    = $urandom_range(0, 1);
            mem_rvalid = $urandom_range(0, 1);
            mem_rdata  = $urandom;
            jump       = ($urandom_range(0, 9) == 0);
            #3;
            if (if_req && ls_req) w_ls = RR ? m_pref_ls : (m_loss != LIMIT);
            else                  w_ls = ls_req;
            e_if_gnt = !m_busy && if_req && !w_ls;
            e_ls_gnt = !m_busy && ls_req && w_ls;
            e_hold   = (if_req && !e_if_gnt) || (m_busy && !m_ls);
            chk("rnd_if_gnt", if_gnt, e_if_gnt);
            chk("rnd_ls_gnt", ls_gnt, e_ls_gnt);
            chk("rnd_mem_req", mem_req, m_busy && !m_acc);
            chk("rnd_hold", hold, e_hold);
            chk("rnd_if_rvalid", if_rvalid, m_if_rv);
            chk("rnd_ls_rvalid", ls_rvalid, m_ls_rv);
            chk("rnd_if_rdata", if_rdata, m_if_rdata);
            chk("rnd_ls_rdata", ls_rdata, m_ls_rdata);
            if (m_busy && !m_acc) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_we", mem_we, m_we);
                chk("rnd_mem_be", mem_be, m_be);
                chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            // advance the model by one cycle
            m_if_rv = 0;
            m_ls_rv = 0;
            if (!m_busy) begin
                if (if_req || ls_req) begin
                    m_busy = 1; m_acc = 0; m_kill = 0; m_ls = w_ls;
                    m_addr  = w_ls ? ls_addr  : if_addr;
                    m_we    = w_ls ? ls_we    : 1'b0;
                    m_be    = w_ls ? ls_be    : 4'hF;
                    m_wdata = w_ls ? ls_wdata : 32'h0;
                    m_pref_ls = !w_ls;
                    if (!w_ls)                          m_loss = 0;
                    else if (if_req && m_loss < LIMIT)  m_loss = m_loss + 1;
                end
            end else begin
                if (jump && !m_ls) m_kill = 1;
                if (!m_acc) begin
                    if (mem_gnt) m_acc = 1;
                end else if (mem_rvalid) begin
                    m_busy = 0;
                    if (m_ls) begin
                        m_ls_rv = 1; m_ls_rdata = mem_rdata;
                    end else if (!m_kill) begin
                        m_if_rv = 1; m_if_rdata = mem_rdata;
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the count of consecutive fetch losses after which fetch wins once (fixed-priority mode only).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have fetch-side ports if_req_i in 1, if_addr_i in 32, if_gnt_o out 1, if_rvalid_o out 1, if_rdata_o out 32.
REQ-005 The block SHALL have load/store-side ports ls_req_i in 1, ls_we_i in 1, ls_be_i in 4, ls_addr_i in 32, ls_wdata_i in 32, ls_gnt_o out 1, ls_rvalid_o out 1, ls_rdata_o out 32.
REQ-006 The block SHALL have memory-side ports mem_req_o out 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 32.
REQ-007 The block SHALL have jump_en_i in 1 (flush from control) and hold_flag_o out 1 (pipeline stall request to control).

Function
REQ-008 The FSM SHALL have states IDLE, REQ, WAIT; at most one memory transaction is outstanding.
REQ-009 In IDLE with any request, the block SHALL pick one winner, pulse its gnt_o combinationally in that cycle, latch its address/we/be/wdata and owner, and move to REQ.
REQ-010 Fetch transactions SHALL drive mem_we_o=0 and mem_be_o=4'b1111.
REQ-011 In REQ, mem_req_o SHALL be 1 with latched fields held stable until mem_gnt_i=1, then move to WAIT.
REQ-012 In WAIT, on mem_rvalid_i=1 the block SHALL register mem_rdata_i into the owner's rdata_o, pulse the owner's rvalid_o for one cycle in the next cycle, and return to IDLE; writes also complete via mem_rvalid_i.
REQ-013 Minimum latency SHALL be: req cycle 0, mem_req_o cycle 1 (mem_gnt_i same cycle), mem_rvalid_i cycle 2, owner rvalid_o cycle 3.
REQ-014 mem_rvalid_i in IDLE or REQ SHALL be ignored; mem_gnt_i outside REQ SHALL be ignored.
REQ-015 If jump_en_i=1 while a fetch transaction is in REQ or WAIT, or in the cycle its rvalid is registered, that fetch's if_rvalid_o SHALL be suppressed; the memory transaction still completes normally.
REQ-016 jump_en_i SHALL not affect load/store transactions.
REQ-017 hold_flag_o SHALL be 1 whenever if_req_i=1 and if_gnt_o=0, or a fetch is in flight and its response has not yet been delivered.
REQ-018 Fixed-priority mode: load/store SHALL win simultaneous requests, except that when the fetch-loss counter equals STARVE_LIMIT fetch SHALL win and the counter SHALL clear.
REQ-019 The fetch-loss counter SHALL increment (saturating at STARVE_LIMIT) on each IDLE arbitration that fetch requests and loses, and clear whenever fetch wins.
REQ-020 rdata_o outputs SHALL hold their last value between responses.

Reset
REQ-021 Asserting rst SHALL immediately force state IDLE, mem_req_o=0, all gnt_o/rvalid_o=0, hold_flag_o=0, rdata_o=0, latched fields=0, counters/pointers=0.
REQ-022 Reset mid-transaction SHALL abandon it; a later mem_rvalid_i SHALL be ignored per REQ-014.

Configuration
REQ-023 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests SHALL alternate by a last-winner pointer (fetch first after reset) and STARVE_LIMIT/counter SHALL be unused; when undefined, REQ-018/019 apply.

Structure
REQ-024 FSM state encodings, owner encoding (OWN_IF=0, OWN_LS=1) and default byte-enable SHALL live in shared package bus_pkg.
REQ-025 Winner selection SHALL be a combinational sub-module arb_pick (inputs: both reqs, pointer/counter; output: winner).

Verification
REQ-026 Single fetch if_addr_i=0x100, mem_rvalid_i in cycle 2 with 0x00000013 -> if_rvalid_o=1 in cycle 3, if_rdata_o=0x00000013.
REQ-027 Simultaneous fetch and store (addr 0x2000, wdata 0xDEADBEEF, be 4'b0011), fixed mode -> ls_gnt_o first, mem_we_o=1, mem_be_o=4'b0011; fetch granted next IDLE.
REQ-028 ls_req_i held high with if_req_i high, STARVE_LIMIT=4 -> fetch granted on the 5th arbitration.
REQ-029 jump_en_i pulse while a fetch is in WAIT -> if_rvalid_o stays 0, FSM returns to IDLE, hold_flag_o drops.
REQ-030 mem_gnt_i held low 10 cycles in REQ -> mem_req_o/mem_addr_o stable; rst low in cycle 5 -> mem_req_o=0 at once, state IDLE.
REQ-031 ARB_ROUND_ROBIN_EN defined, both requesting continuously -> grants alternate IF, LS, IF, LS.
